vector_mem_sequencer: RTL
=========================

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 The block SHALL have parameter dataSize, default 32, giving the bit width of one vector lane.
REQ-002 The block SHALL have parameter addressingSize, default 32, giving the byte address width.
REQ-003 The block SHALL have parameter vecSize, default 4, giving the number of lanes per vector.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a transfer request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the sequencer can accept a request.
REQ-008 The block SHALL have port req_write, input, 1 bit: 1 = store burst, 0 = load burst.
REQ-009 The block SHALL have port req_addr, input, addressingSize bits: base byte address of the first vector.
REQ-010 The block SHALL have port req_count, input, 8 bits: number of vectors in the burst.
REQ-011 The block SHALL have ports wd_valid (input, 1), wd_ready (output, 1) and wd_data (input, vecSize x dataSize): the store data stream.
REQ-012 The block SHALL have ports rd_valid (output, 1), rd_ready (input, 1) and rd_data (output, vecSize x dataSize): the load data stream.
REQ-013 The block SHALL have ports mem_we (output, 1), mem_addr (output, addressingSize), mem_wdata (output, vecSize x dataSize) and mem_rdata (input, vecSize x dataSize): the data-memory side.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-015 The block SHALL implement FSM states IDLE, ST_XFER, LD_ADDR, LD_DATA and FINISH.
REQ-016 In IDLE the block SHALL assert req_ready; a request is accepted on req_valid && req_ready, and address, count and direction are latched.
REQ-017 On acceptance the block SHALL go to ST_XFER if req_write=1, LD_ADDR if req_write=0, and FINISH if req_count=0, with no memory access for a zero count.
REQ-018 In ST_XFER the block SHALL assert wd_ready, with mem_we = wd_valid (combinational), mem_wdata = wd_data and mem_addr = current address.
REQ-019 Each ST_XFER cycle with wd_valid=1 SHALL write one vector, add vecSize*dataSize/8 to the address (16 at defaults, wrapping modulo 2^addressingSize) and decrement the remaining count.
REQ-020 In LD_ADDR the block SHALL drive mem_addr with mem_we=0 and go to LD_DATA on the next cycle; memory read latency is one cycle.
REQ-021 In LD_DATA the block SHALL assert rd_valid with rd_data = mem_rdata, holding mem_addr stable and mem_we=0 so that rd_data stays stable while rd_ready=0.
REQ-022 On rd_valid && rd_ready the block SHALL advance the address and decrement the count, going to LD_ADDR if vectors remain and to FINISH otherwise.
REQ-023 After the last store write the block SHALL go to FINISH.
REQ-024 In FINISH the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-025 mem_we SHALL be 0 in every state other than ST_XFER.
REQ-026 req_ready, wd_ready and rd_valid SHALL be 0 outside IDLE, ST_XFER and LD_DATA respectively.
REQ-027 req_valid SHALL be ignored outside IDLE, so that no request is queued.
REQ-028 Load throughput SHALL be at most one vector per two cycles; store throughput SHALL be at most one vector per cycle.

Reset
REQ-029 While rst_n=0 the FSM SHALL be in IDLE, with address and count 0, mem_we=0, done=0, rd_valid=0 and wd_ready=0.
REQ-030 req_ready SHALL be 0 while rst_n=0 and 1 on the first cycle after release.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately, with no further memory writes and no done pulse.

Configuration
REQ-032 Macro VMS_ALIGN_CHECK_EN SHALL control alignment checking.
REQ-033 With VMS_ALIGN_CHECK_EN defined, output port err (1 bit) SHALL exist; a request whose req_addr low log2(dataSize/8) bits are nonzero is accepted, performs no memory access, and pulses err and done together in FINISH.
REQ-034 Without VMS_ALIGN_CHECK_EN, err SHALL be absent and the low address bits SHALL pass through unchecked.

Verification
REQ-035 Store burst addr=0x100, count=3, wd_valid held 1 -> mem_we high for 3 consecutive cycles at 0x100, 0x110 and 0x120, then one done pulse.
REQ-036 Load burst addr=0x40, count=2, rd_ready=1 -> rd_valid on cycles 2 and 4 after acceptance, with rd_data equal to memory contents at 0x40 and 0x50.
REQ-037 Load with rd_ready held 0 for 5 cycles -> rd_valid and rd_data stable, mem_addr unchanged, mem_we=0 throughout.
REQ-038 Store with wd_valid toggling 1,0,1,0,1, count=3 -> exactly 3 writes, with the address advancing only on valid cycles.
REQ-039 req_count=0 -> no mem_we, done one cycle after acceptance; rst_n pulled low mid-store -> mem_we=0 at once, no done pulse, req_ready=1 after release.
REQ-040 With VMS_ALIGN_CHECK_EN defined, addr=0x102 -> err and done pulse together and mem_we stays 0.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - vector load/store burst sequencer between request/data streams and a 1-cycle-latency memory.
// Optional macro VMS_ALIGN_CHECK_EN adds the err output and rejects lane-misaligned base addresses.
module vector_mem_sequencer #(
    parameter int dataSize       = 32,
    parameter int addressingSize = 32,
    parameter int vecSize        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [addressingSize-1:0]     req_addr,
    input  logic [7:0]                    req_count,
    input  logic                          wd_valid,
    output logic                          wd_ready,
    input  logic [vecSize*dataSize-1:0]   wd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [vecSize*dataSize-1:0]   rd_data,
    output logic                          mem_we,
    output logic [addressingSize-1:0]     mem_addr,
    output logic [vecSize*dataSize-1:0]   mem_wdata,
    input  logic [vecSize*dataSize-1:0]   mem_rdata,
`ifdef VMS_ALIGN_CHECK_EN
    output logic                          err,
`endif
    output logic                          done
);

    localparam logic [addressingSize-1:0] STEP = addressingSize'(vecSize * dataSize / 8);

    typedef enum logic [2:0] {
        IDLE,
        ST_XFER,
        LD_ADDR,
        LD_DATA,
        FINISH
    } state_t;

    state_t                    r_state;
    logic [addressingSize-1:0] r_addr;
    logic [7:0]                r_count;
    logic                      w_last;
    logic                      w_skip;

    assign w_last = (r_count == 8'd1);

`ifdef VMS_ALIGN_CHECK_EN
    localparam logic [addressingSize-1:0] ALIGN_MASK = addressingSize'(dataSize / 8 - 1);
    logic r_err;
    logic w_misaligned;

    assign w_misaligned = |(req_addr & ALIGN_MASK);
    assign w_skip       = (req_count == 8'd0) || w_misaligned;
    assign err          = done && r_err;
`else
    assign w_skip = (req_count == 8'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_count <= '0;
`ifdef VMS_ALIGN_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_count <= req_count;
`ifdef VMS_ALIGN_CHECK_EN
                        r_err   <= w_misaligned;
`endif
                        if (w_skip)
                            r_state <= FINISH;
                        else if (req_write)
                            r_state <= ST_XFER;
                        else
                            r_state <= LD_ADDR;
                    end
                end
                ST_XFER: begin
                    if (wd_valid) begin
                        r_addr  <= r_addr + STEP;
                        r_count <= r_count - 8'd1;
                        if (w_last)
                            r_state <= FINISH;
                    end
                end
                LD_ADDR: r_state <= LD_DATA;
                // Address is held through LD_DATA so the registered read data stays put while stalled.
                LD_DATA: begin
                    if (rd_ready) begin
                        r_addr  <= r_addr + STEP;
                        r_count <= r_count - 8'd1;
                        r_state <= w_last ? FINISH : LD_ADDR;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
`ifdef VMS_ALIGN_CHECK_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = rst_n && (r_state == IDLE);
    assign wd_ready  = (r_state == ST_XFER);
    assign mem_we    = wd_ready && wd_valid;
    assign mem_wdata = wd_data;
    assign mem_addr  = r_addr;
    assign rd_valid  = (r_state == LD_DATA);
    assign rd_data   = mem_rdata;
    assign done      = (r_state == FINISH);

endmodule
